// File: rtl/match_sideband_realign_if.sv
// Sideband realign bus: push/pop handshake from the match pipeline plus the
// realigned output word and FIFO status. Signal names are from the FIFO's view.
interface match_sideband_realign_if #(
    parameter int Pra_Width = 32,
    parameter int Pra_Depth = 16
);
    localparam int CntW = $clog2(Pra_Depth) + 1;

    logic                 i_clear;
    logic                 i_push;
    logic [Pra_Width-1:0] i_push_data;
    logic                 i_pop;
    logic [Pra_Width-1:0] o_data;
    logic                 o_valid;
    logic [CntW-1:0]      o_count;
    logic                 o_full;
    logic                 o_empty;
    logic                 o_overflow;
    logic                 o_underflow;

    // FIFO side
    modport slave (
        input  i_clear, i_push, i_push_data, i_pop,
        output o_data, o_valid, o_count, o_full, o_empty, o_overflow, o_underflow
    );

    // Feeder / result-writer side
    modport master (
        output i_clear, i_push, i_push_data, i_pop,
        input  o_data, o_valid, o_count, o_full, o_empty, o_overflow, o_underflow
    );
endinterface

// File: rtl/match_sideband_realign.sv
// Variable-latency sideband realigner: an in-order FIFO that captures a
// sideband word when a descriptor enters the match pipeline and releases it
// when that pipeline's result-valid emerges, whatever the pipeline depth.
module match_sideband_realign #(
    parameter int Pra_Width = 32,
    parameter int Pra_Depth = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    match_sideband_realign_if.slave  bus
);
    localparam int AddrW = $clog2(Pra_Depth);
    localparam int PtrW  = AddrW + 1;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [PtrW-1:0]      r_wr_ptr;
    logic [PtrW-1:0]      r_rd_ptr;
    logic [Pra_Width-1:0] r_mem [Pra_Depth];
    logic [Pra_Width-1:0] r_data;
    logic                 r_valid;
    logic                 r_overflow;
    logic                 r_underflow;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push_ok;
    logic                 w_pop_ok;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AddrW-1:0] == r_rd_ptr[AddrW-1:0]) &&
                     (r_wr_ptr[AddrW] != r_rd_ptr[AddrW]);

    // A full FIFO still accepts a push when the same cycle pops (full implies
    // non-empty, so that pop is always accepted and frees the slot).
    assign w_push_ok = !bus.i_clear && bus.i_push && (!w_full || bus.i_pop);
    // No push->pop bypass: a word is only poppable the cycle after its push.
    assign w_pop_ok  = !bus.i_clear && bus.i_pop && !w_empty;

    // Sideband storage write port.
    // NOTE: the RAM has no reset; its contents are don't-care until written,
    // and leaving it out of reset lets synthesis map it onto plain RAM.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[AddrW-1:0]] <= bus.i_push_data;
        end
    end

    // Pointer, output register and sticky flag update; clear outranks push/pop.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (bus.i_clear) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_valid     <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_valid <= w_pop_ok;
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PtrW'(1);
            end else if (bus.i_push) begin
                r_overflow <= 1'b1;
            end
            if (w_pop_ok) begin
                r_data   <= r_mem[r_rd_ptr[AddrW-1:0]];
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end else if (bus.i_pop) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign bus.o_data      = r_data;
    assign bus.o_valid     = r_valid;
    assign bus.o_count     = r_wr_ptr - r_rd_ptr;
    assign bus.o_full      = w_full;
    assign bus.o_empty     = w_empty;
    assign bus.o_overflow  = r_overflow;
    assign bus.o_underflow = r_underflow;
endmodule

// File: tb/tb_match_sideband_realign.sv
// Directed bench for match_sideband_realign: reset, ordering, full/overflow,
// full push+pop, underflow and pointer wrap followed by clear.
module tb_match_sideband_realign;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    match_sideband_realign_if #(.Pra_Width(32), .Pra_Depth(16)) bus ();

    match_sideband_realign #(.Pra_Width(32), .Pra_Depth(16)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, advance past the edge, then idle the inputs.
    task automatic step(input logic push, input logic [31:0] d, input logic pop, input logic clr);
        bus.i_push      = push;
        bus.i_push_data = d;
        bus.i_pop       = pop;
        bus.i_clear     = clr;
        @(posedge clk);
        #1;
        bus.i_push  = 1'b0;
        bus.i_pop   = 1'b0;
        bus.i_clear = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n           = 1'b0;
        bus.i_push      = 1'b0;
        bus.i_push_data = '0;
        bus.i_pop       = 1'b0;
        bus.i_clear     = 1'b0;
        #12;
        check("rst_count", 32'(bus.o_count), 32'd0);
        check("rst_empty", 32'(bus.o_empty), 32'd1);
        check("rst_full",  32'(bus.o_full), 32'd0);
        check("rst_flags", {30'd0, bus.o_overflow, bus.o_underflow}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset mid-stream with 5 words stored and a nonzero o_data
        for (int i = 0; i < 6; i++) step(1'b1, 32'h11 + 32'(i), 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        check("pre_rst_data",  bus.o_data, 32'h11);
        check("pre_rst_count", 32'(bus.o_count), 32'd5);
        rst_n = 1'b0;
        #1;
        check("async_rst_count", 32'(bus.o_count), 32'd0);
        check("async_rst_empty", 32'(bus.o_empty), 32'd1);
        check("async_rst_valid", 32'(bus.o_valid), 32'd0);
        check("async_rst_data",  bus.o_data, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // In-order release with a 7-cycle gap between pops
        for (int i = 0; i < 4; i++) step(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0);
        check("inorder_count", 32'(bus.o_count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 32'd0, 1'b1, 1'b0);
            check("inorder_valid", 32'(bus.o_valid), 32'd1);
            check("inorder_data",  bus.o_data, 32'hA0 + 32'(i));
            step(1'b0, 32'd0, 1'b0, 1'b0);
            check("inorder_pulse_end", 32'(bus.o_valid), 32'd0);
            check("inorder_data_hold", bus.o_data, 32'hA0 + 32'(i));
            repeat (6) step(1'b0, 32'd0, 1'b0, 1'b0);
        end
        check("inorder_empty", 32'(bus.o_empty), 32'd1);

        // Fill to 16, 17th push dropped with overflow
        for (int i = 1; i <= 15; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
        check("fill15_full", 32'(bus.o_full), 32'd0);
        step(1'b1, 32'd16, 1'b0, 1'b0);
        check("fill16_full",  32'(bus.o_full), 32'd1);
        check("fill16_count", 32'(bus.o_count), 32'd16);
        check("fill16_ovf",   32'(bus.o_overflow), 32'd0);
        step(1'b1, 32'd17, 1'b0, 1'b0);
        check("ovf_flag",  32'(bus.o_overflow), 32'd1);
        check("ovf_count", 32'(bus.o_count), 32'd16);
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 32'd0, 1'b1, 1'b0);
            check("drain_data", bus.o_data, 32'(i));
        end
        check("drain_empty",  32'(bus.o_empty), 32'd1);
        check("ovf_sticky",   32'(bus.o_overflow), 32'd1);

        // Clear sticky flag, then push+pop while full
        step(1'b0, 32'd0, 1'b0, 1'b1);
        check("clear_ovf", 32'(bus.o_overflow), 32'd0);
        for (int i = 0; i < 16; i++) step(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
        check("refill_full", 32'(bus.o_full), 32'd1);
        step(1'b1, 32'hBB, 1'b1, 1'b0);
        check("fullpp_valid", 32'(bus.o_valid), 32'd1);
        check("fullpp_data",  bus.o_data, 32'h100);
        check("fullpp_count", 32'(bus.o_count), 32'd16);
        check("fullpp_ovf",   32'(bus.o_overflow), 32'd0);
        for (int i = 1; i < 16; i++) begin
            step(1'b0, 32'd0, 1'b1, 1'b0);
            check("fullpp_drain", bus.o_data, 32'h100 + 32'(i));
        end
        step(1'b0, 32'd0, 1'b1, 1'b0);
        check("fullpp_last", bus.o_data, 32'hBB);
        check("fullpp_empty", 32'(bus.o_empty), 32'd1);

        // Underflow with a same-cycle push into the empty FIFO
        step(1'b1, 32'hCC, 1'b1, 1'b0);
        check("unf_valid", 32'(bus.o_valid), 32'd0);
        check("unf_flag",  32'(bus.o_underflow), 32'd1);
        check("unf_count", 32'(bus.o_count), 32'd1);
        check("unf_hold",  bus.o_data, 32'hBB);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        check("unf_next_valid", 32'(bus.o_valid), 32'd1);
        check("unf_next_data",  bus.o_data, 32'hCC);
        check("unf_sticky",     32'(bus.o_underflow), 32'd1);

        // Steady-state streaming at depth 3 through several pointer wraps
        step(1'b0, 32'd0, 1'b0, 1'b1);
        check("clear_unf", 32'(bus.o_underflow), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 32'hD00 + 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 32'hD03 + 32'(i), 1'b1, 1'b0);
            check("wrap_data",  bus.o_data, 32'hD00 + 32'(i));
            check("wrap_count", 32'(bus.o_count), 32'd3);
        end
        check("wrap_flags", {30'd0, bus.o_overflow, bus.o_underflow}, 32'd0);

        // Clear outranks a same-cycle push
        step(1'b1, 32'hEE, 1'b0, 1'b1);
        check("clr_count", 32'(bus.o_count), 32'd0);
        check("clr_empty", 32'(bus.o_empty), 32'd1);
        check("clr_valid", 32'(bus.o_valid), 32'd0);
        check("clr_hold",  bus.o_data, 32'hD27);
        check("clr_flags", {30'd0, bus.o_overflow, bus.o_underflow}, 32'd0);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        check("clr_discard_valid", 32'(bus.o_valid), 32'd0);
        check("clr_discard_unf",   32'(bus.o_underflow), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
